// File: rtl/vout_timing_cfg_ctrl_pkg.sv
// Shared types and constants for the video-out timing configuration controller:
// default 1080p mode, register address map, FSM states and the set validator.
package vout_timing_cfg_ctrl_pkg;

  localparam int DATA_W          = 12;
  localparam int NUM_REGS        = 10;
  localparam int NUM_SEG_DEF     = 6;
  localparam int RST_CYC_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 1 << 22;

  localparam logic [3:0] ADDR_H_FP     = 4'd0;
  localparam logic [3:0] ADDR_H_SYNC   = 4'd1;
  localparam logic [3:0] ADDR_H_BP     = 4'd2;
  localparam logic [3:0] ADDR_H_ACTIVE = 4'd3;
  localparam logic [3:0] ADDR_H_TOTAL  = 4'd4;
  localparam logic [3:0] ADDR_V_FP     = 4'd5;
  localparam logic [3:0] ADDR_V_SYNC   = 4'd6;
  localparam logic [3:0] ADDR_V_BP     = 4'd7;
  localparam logic [3:0] ADDR_V_ACTIVE = 4'd8;
  localparam logic [3:0] ADDR_V_TOTAL  = 4'd9;

  // One complete mode; element index equals the cfg_addr of that value.
  typedef logic [NUM_REGS-1:0][DATA_W-1:0] timing_set_t;

  localparam timing_set_t DEFAULT_TIMING = {
    12'd1125, 12'd1080, 12'd36, 12'd5, 12'd4,
    12'd2200, 12'd1920, 12'd148, 12'd44, 12'd88
  };
  localparam logic [DATA_W-1:0] DEFAULT_H_CLK_CNT = 12'd320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIV,
    ST_ERR,
    ST_WAIT_VS,
    ST_HOLD
  } state_e;

  // True when the porch/sync/active sums do not match the totals or a
  // sync/active width is zero. Sums are kept at 13 bits on purpose.
  function automatic logic check_fail(input timing_set_t s);
    logic [DATA_W:0] h_sum;
    logic [DATA_W:0] v_sum;
    h_sum = 13'(s[ADDR_H_FP]) + 13'(s[ADDR_H_SYNC]) + 13'(s[ADDR_H_BP])
          + 13'(s[ADDR_H_ACTIVE]);
    v_sum = 13'(s[ADDR_V_FP]) + 13'(s[ADDR_V_SYNC]) + 13'(s[ADDR_V_BP])
          + 13'(s[ADDR_V_ACTIVE]);
    return (h_sum != {1'b0, s[ADDR_H_TOTAL]}) ||
           (v_sum != {1'b0, s[ADDR_V_TOTAL]}) ||
           (s[ADDR_H_SYNC] == '0) || (s[ADDR_V_SYNC] == '0) ||
           (s[ADDR_H_ACTIVE] == '0) || (s[ADDR_V_ACTIVE] == '0);
  endfunction

endpackage

// File: rtl/vout_timing_cfg_ctrl_if.sv
// Host-side configuration bus: shadow writes, commit request and status.
interface vout_timing_cfg_ctrl_if;
  import vout_timing_cfg_ctrl_pkg::*;

  logic              cfg_wr;
  logic [3:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_commit;
  logic              cfg_busy;
  logic              cfg_done;
  logic              cfg_err;

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
    input  cfg_busy, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
    output cfg_busy, cfg_done, cfg_err
  );
endinterface

// File: rtl/vout_timing_cfg_ctrl_seq_div12.sv
// Restoring divider, one quotient bit per cycle. The first bit is resolved in
// the start cycle itself, so results are registered 12 cycles after start and
// done_o is high for the one cycle in which they first become valid.
module vout_timing_cfg_ctrl_seq_div12 (
  input  logic        dp_clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [11:0] dividend_i,
  input  logic [11:0] divisor_i,
  output logic        done_o,
  output logic [11:0] quotient_o,
  output logic [11:0] remainder_o
);

  logic [11:0] rem_q, quo_q, rem_d, quo_d;
  logic [3:0]  cnt_q;
  logic        busy_q, done_q;
  logic [11:0] rem_in, quo_in;
  logic [12:0] rem_sh;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_in = start_i ? 12'd0 : rem_q;
    quo_in = start_i ? dividend_i : quo_q;
    rem_sh = {rem_in, quo_in[11]};
    rem_d  = rem_sh[11:0];
    quo_d  = {quo_in[10:0], 1'b0};
    if (rem_sh >= {1'b0, divisor_i}) begin
      rem_d = 12'(rem_sh - {1'b0, divisor_i});
      quo_d = {quo_in[10:0], 1'b1};
    end
  end

  // Iteration counter and working registers.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        cnt_q  <= 4'd11;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/vout_timing_cfg_ctrl.sv
// Run-time mode controller for the display timing generator: shadow register
// file, set validation, segment-length division and vsync-aligned apply with a
// timing-generator restart pulse.
module vout_timing_cfg_ctrl
  import vout_timing_cfg_ctrl_pkg::*;
#(
  parameter int NUM_SEG     = NUM_SEG_DEF,
  parameter int RST_CYC     = RST_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   dp_clk,
  input  logic                   rst_n,
  vout_timing_cfg_ctrl_if.slave  cfg,
  input  logic                   vs_in_i,
  output logic [DATA_W-1:0]      h_fp_o,
  output logic [DATA_W-1:0]      h_sync_o,
  output logic [DATA_W-1:0]      h_bp_o,
  output logic [DATA_W-1:0]      h_active_o,
  output logic [DATA_W-1:0]      h_total_o,
  output logic [DATA_W-1:0]      v_fp_o,
  output logic [DATA_W-1:0]      v_sync_o,
  output logic [DATA_W-1:0]      v_bp_o,
  output logic [DATA_W-1:0]      v_active_o,
  output logic [DATA_W-1:0]      v_total_o,
  output logic [DATA_W-1:0]      h_clk_cnt_o,
  output logic                   tg_rst_n_o
);

  localparam int TMR_W  = $clog2(TIMEOUT_CYC);
  localparam int HOLD_W = $clog2(RST_CYC + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYC - 1);

  state_e            state_q, state_d;
  timing_set_t       shadow_q, shadow_d, active_q;
  logic [DATA_W-1:0] h_clk_cnt_q;
  logic              err_q, done_q, tg_rst_n_q, vs_q, chk_fail_q;
  logic [TMR_W-1:0]  timer_q;
  logic [HOLD_W-1:0] hold_cnt_q;

  logic              commit_acc, wr_en, vs_edge, apply, hold_last;
  logic              div_start, div_done, div_fail, busy;
  logic [DATA_W-1:0] quotient, remainder;

  vout_timing_cfg_ctrl_seq_div12 u_div (
    .dp_clk      (dp_clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (shadow_q[ADDR_H_ACTIVE]),
    .divisor_i   (12'(NUM_SEG)),
    .done_o      (div_done),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  // State register.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: commit -> check -> divide -> error or wait for vsync -> hold.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (commit_acc) state_d = ST_CHECK;
      ST_CHECK:   state_d = ST_DIV;
      ST_DIV:     if (div_done) state_d = div_fail ? ST_ERR : ST_WAIT_VS;
      ST_ERR:     state_d = ST_IDLE;
      ST_WAIT_VS: if (apply) state_d = ST_HOLD;
      ST_HOLD:    if (hold_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Control decode from the current state and inputs.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    commit_acc = (state_q == ST_IDLE) && cfg.cfg_commit;
    wr_en      = (state_q == ST_IDLE) && cfg.cfg_wr &&
                 (cfg.cfg_addr < 4'(NUM_REGS));
    vs_edge    = vs_in_i & ~vs_q;
    apply      = (state_q == ST_WAIT_VS) && (vs_edge || (timer_q == TMR_LAST));
    hold_last  = (state_q == ST_HOLD) && (hold_cnt_q == HOLD_LAST);
    div_start  = (state_q == ST_CHECK);
    div_fail   = chk_fail_q || (remainder != '0);
  end

  // Shadow write port; only the addressed entry changes.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (cfg.cfg_addr == 4'(i))) shadow_d[i] = cfg.cfg_wdata;
    end
  end

  // Shadow and active mode registers; active set only moves on apply.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= DEFAULT_TIMING;
      active_q    <= DEFAULT_TIMING;
      h_clk_cnt_q <= DEFAULT_H_CLK_CNT;
    end else begin
      shadow_q <= shadow_d;
      if (apply) begin
        active_q    <= shadow_q;
        h_clk_cnt_q <= quotient;
      end
    end
  end

  // Status flags, vsync history, wait timer, hold counter and restart pulse.
  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      chk_fail_q <= 1'b0;
      timer_q    <= '0;
      hold_cnt_q <= '0;
      tg_rst_n_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vs_q       <= vs_in_i;
      if (div_start) chk_fail_q <= check_fail(shadow_q);
      timer_q    <= (state_q == ST_WAIT_VS) ? timer_q + 1'b1 : '0;
      hold_cnt_q <= (state_q == ST_HOLD) ? hold_cnt_q + 1'b1 : '0;
      if (apply)          tg_rst_n_q <= 1'b0;
      else if (hold_last) tg_rst_n_q <= 1'b1;
      done_q <= ((state_q == ST_DIV) && div_done && div_fail) || hold_last;
      if (commit_acc)                                     err_q <= 1'b0;
      else if ((state_q == ST_DIV) && div_done && div_fail) err_q <= 1'b1;
    end
  end

  assign cfg.cfg_busy = busy;
  assign cfg.cfg_done = done_q;
  assign cfg.cfg_err  = err_q;

  assign h_fp_o      = active_q[ADDR_H_FP];
  assign h_sync_o    = active_q[ADDR_H_SYNC];
  assign h_bp_o      = active_q[ADDR_H_BP];
  assign h_active_o  = active_q[ADDR_H_ACTIVE];
  assign h_total_o   = active_q[ADDR_H_TOTAL];
  assign v_fp_o      = active_q[ADDR_V_FP];
  assign v_sync_o    = active_q[ADDR_V_SYNC];
  assign v_bp_o      = active_q[ADDR_V_BP];
  assign v_active_o  = active_q[ADDR_V_ACTIVE];
  assign v_total_o   = active_q[ADDR_V_TOTAL];
  assign h_clk_cnt_o = h_clk_cnt_q;
  assign tg_rst_n_o  = tg_rst_n_q;

endmodule

// File: tb/tb_vout_timing_cfg_ctrl.sv
// Directed bench for the timing configuration controller.
module tb_vout_timing_cfg_ctrl;
  import vout_timing_cfg_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 64;

  localparam timing_set_t SET_1080 = {
    12'd1125, 12'd1080, 12'd36, 12'd5, 12'd4,
    12'd2200, 12'd1920, 12'd148, 12'd44, 12'd88 };
  localparam timing_set_t SET_A = {
    12'd930, 12'd900, 12'd21, 12'd6, 12'd3,
    12'd1392, 12'd1200, 12'd120, 12'd48, 12'd24 };
  localparam timing_set_t SET_B = {
    12'd930, 12'd900, 12'd21, 12'd6, 12'd3,
    12'd1650, 12'd1280, 12'd220, 12'd40, 12'd110 };
  localparam timing_set_t SET_C = {
    12'd1125, 12'd1080, 12'd36, 12'd5, 12'd4,
    12'd2199, 12'd1920, 12'd148, 12'd44, 12'd88 };

  logic        dp_clk = 1'b0;
  logic        rst_n;
  logic        vs_in;
  logic [11:0] h_fp, h_sync, h_bp, h_active, h_total;
  logic [11:0] v_fp, v_sync, v_bp, v_active, v_total;
  logic [11:0] h_clk_cnt;
  logic        tg_rst_n;
  timing_set_t obsSet;

  int compared   = 0;
  int mismatched = 0;

  vout_timing_cfg_ctrl_if cfgIf ();

  vout_timing_cfg_ctrl #(
    .NUM_SEG     (6),
    .RST_CYC     (4),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .dp_clk      (dp_clk),
    .rst_n       (rst_n),
    .cfg         (cfgIf),
    .vs_in_i     (vs_in),
    .h_fp_o      (h_fp),
    .h_sync_o    (h_sync),
    .h_bp_o      (h_bp),
    .h_active_o  (h_active),
    .h_total_o   (h_total),
    .v_fp_o      (v_fp),
    .v_sync_o    (v_sync),
    .v_bp_o      (v_bp),
    .v_active_o  (v_active),
    .v_total_o   (v_total),
    .h_clk_cnt_o (h_clk_cnt),
    .tg_rst_n_o  (tg_rst_n)
  );

  assign obsSet = {v_total, v_active, v_bp, v_sync, v_fp,
                   h_total, h_active, h_bp, h_sync, h_fp};

  always #5 dp_clk = ~dp_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge dp_clk);
    #1;
  endtask

  task automatic sampleMid();
    @(negedge dp_clk);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) nextCycle();
  endtask

  task automatic applyStimulus(input logic wr, input logic [3:0] addr,
                               input logic [11:0] data, input logic commit);
    cfgIf.cfg_wr     = wr;
    cfgIf.cfg_addr   = addr;
    cfgIf.cfg_wdata  = data;
    cfgIf.cfg_commit = commit;
    nextCycle();
    cfgIf.cfg_wr     = 1'b0;
    cfgIf.cfg_addr   = 4'd0;
    cfgIf.cfg_wdata  = 12'd0;
    cfgIf.cfg_commit = 1'b0;
  endtask

  task automatic loadShadow(input timing_set_t s);
    for (int i = 0; i < NUM_REGS; i++) applyStimulus(1'b1, 4'(i), s[i], 1'b0);
  endtask

  task automatic checkActive(input string tag, input timing_set_t exp,
                             input logic [11:0] expClk);
    for (int i = 0; i < NUM_REGS; i++)
      checkOutput($sformatf("%s_reg%0d", tag, i), obsSet[i], exp[i]);
    checkOutput({tag, "_h_clk_cnt"}, h_clk_cnt, expClk);
  endtask

  // Samples n consecutive cycles starting with the current one.
  task automatic observeWindow(input int n, output int lowCnt, output int firstLow,
                               output int doneCnt, output int firstDone,
                               output int busyAtDone);
    lowCnt = 0; firstLow = -1; doneCnt = 0; firstDone = -1; busyAtDone = -1;
    for (int k = 0; k < n; k++) begin
      sampleMid();
      if (tg_rst_n === 1'b0) begin
        lowCnt++;
        if (firstLow < 0) firstLow = k;
      end
      if (cfgIf.cfg_done === 1'b1) begin
        doneCnt++;
        if (firstDone < 0) begin
          firstDone  = k;
          busyAtDone = int'(cfgIf.cfg_busy);
        end
      end
      nextCycle();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowCnt, firstLow, doneCnt, firstDone, busyAtDone;

    rst_n = 1'b0;
    vs_in = 1'b0;
    cfgIf.cfg_wr = 1'b0; cfgIf.cfg_addr = 4'd0;
    cfgIf.cfg_wdata = 12'd0; cfgIf.cfg_commit = 1'b0;

    // Reset values
    repeat (2) @(posedge dp_clk);
    #1;
    checkActive("rst", SET_1080, 12'd320);
    checkOutput("rst_tg", tg_rst_n, 1);
    checkOutput("rst_busy", cfgIf.cfg_busy, 0);
    checkOutput("rst_done", cfgIf.cfg_done, 0);
    checkOutput("rst_err", cfgIf.cfg_err, 0);
    rst_n = 1'b1;
    nextCycle();

    // Valid mode applied on a vsync rising edge
    $display("[TB] valid commit, vsync apply");
    loadShadow(SET_A);
    applyStimulus(1'b0, 4'd0, 12'd0, 1'b1);
    sampleMid();
    checkOutput("a_busy_n1", cfgIf.cfg_busy, 1);
    checkOutput("a_done_n1", cfgIf.cfg_done, 0);
    waitCycles(13);
    sampleMid();
    checkOutput("a_busy_n14", cfgIf.cfg_busy, 1);
    checkOutput("a_done_n14", cfgIf.cfg_done, 0);
    checkOutput("a_err_n14", cfgIf.cfg_err, 0);
    nextCycle();
    vs_in = 1'b1;
    sampleMid();
    checkOutput("a_hact_pre", h_active, 1920);
    checkOutput("a_tg_pre", tg_rst_n, 1);
    nextCycle();
    observeWindow(8, lowCnt, firstLow, doneCnt, firstDone, busyAtDone);
    checkOutput("a_tg_low_len", lowCnt, 4);
    checkOutput("a_tg_low_first", firstLow, 0);
    checkOutput("a_done_cnt", doneCnt, 1);
    checkOutput("a_done_pos", firstDone, 4);
    checkOutput("a_busy_at_done", busyAtDone, 0);
    checkActive("a_act", SET_A, 12'd200);
    vs_in = 1'b0;

    // Divide remainder failure: 1280/6
    $display("[TB] remainder error");
    loadShadow(SET_B);
    applyStimulus(1'b0, 4'd0, 12'd0, 1'b1);
    sampleMid();
    checkOutput("b_busy_n1", cfgIf.cfg_busy, 1);
    waitCycles(12);
    sampleMid();
    checkOutput("b_done_n13", cfgIf.cfg_done, 0);
    nextCycle();
    sampleMid();
    checkOutput("b_done_n14", cfgIf.cfg_done, 1);
    checkOutput("b_err_n14", cfgIf.cfg_err, 1);
    checkOutput("b_tg_n14", tg_rst_n, 1);
    nextCycle();
    sampleMid();
    checkOutput("b_done_n15", cfgIf.cfg_done, 0);
    checkOutput("b_busy_n15", cfgIf.cfg_busy, 0);
    checkOutput("b_err_n15", cfgIf.cfg_err, 1);
    checkActive("b_act", SET_A, 12'd200);
    nextCycle();

    // Sum mismatch: h_total 2199; err cleared at accept then set again
    $display("[TB] sum error");
    loadShadow(SET_C);
    applyStimulus(1'b0, 4'd0, 12'd0, 1'b1);
    sampleMid();
    checkOutput("c_err_clr_n1", cfgIf.cfg_err, 0);
    waitCycles(13);
    sampleMid();
    checkOutput("c_done_n14", cfgIf.cfg_done, 1);
    checkOutput("c_err_n14", cfgIf.cfg_err, 1);
    nextCycle();

    // Fix h_total, apply by timeout; busy-time write and commit are dropped
    $display("[TB] timeout apply with dropped traffic");
    applyStimulus(1'b1, ADDR_H_TOTAL, 12'd2200, 1'b0);
    applyStimulus(1'b0, 4'd0, 12'd0, 1'b1);
    sampleMid();
    checkOutput("d_err_clr_n1", cfgIf.cfg_err, 0);
    waitCycles(19);
    applyStimulus(1'b1, ADDR_H_ACTIVE, 12'd1234, 1'b1);
    waitCycles(56);
    sampleMid();
    checkOutput("d_htot_n77", h_total, 1392);
    checkOutput("d_tg_n77", tg_rst_n, 1);
    checkOutput("d_busy_n77", cfgIf.cfg_busy, 1);
    nextCycle();
    observeWindow(8, lowCnt, firstLow, doneCnt, firstDone, busyAtDone);
    checkOutput("d_tg_low_first", firstLow, 0);
    checkOutput("d_tg_low_len", lowCnt, 4);
    checkOutput("d_done_cnt", doneCnt, 1);
    checkOutput("d_done_pos", firstDone, 4);
    checkActive("d_act", SET_1080, 12'd320);
    checkOutput("d_err_end", cfgIf.cfg_err, 0);

    // Same-cycle write and commit: check must see the new h_total
    $display("[TB] same-cycle write and commit");
    for (int i = 0; i < NUM_REGS; i++)
      if (i != int'(ADDR_H_TOTAL)) applyStimulus(1'b1, 4'(i), SET_A[i], 1'b0);
    applyStimulus(1'b1, ADDR_H_TOTAL, 12'd1392, 1'b1);
    waitCycles(13);
    sampleMid();
    checkOutput("e_done_n14", cfgIf.cfg_done, 0);
    checkOutput("e_err_n14", cfgIf.cfg_err, 0);
    checkOutput("e_busy_n14", cfgIf.cfg_busy, 1);
    nextCycle();
    vs_in = 1'b1;
    nextCycle();
    observeWindow(8, lowCnt, firstLow, doneCnt, firstDone, busyAtDone);
    checkOutput("e_tg_low_len", lowCnt, 4);
    checkOutput("e_done_pos", firstDone, 4);
    checkActive("e_act", SET_A, 12'd200);
    vs_in = 1'b0;

    // Reset while waiting for vsync
    $display("[TB] reset during wait");
    applyStimulus(1'b0, 4'd0, 12'd0, 1'b1);
    waitCycles(19);
    rst_n = 1'b0;
    #2;
    checkActive("f_rst", SET_1080, 12'd320);
    checkOutput("f_busy", cfgIf.cfg_busy, 0);
    checkOutput("f_done", cfgIf.cfg_done, 0);
    checkOutput("f_err", cfgIf.cfg_err, 0);
    checkOutput("f_tg", tg_rst_n, 1);
    nextCycle();
    rst_n = 1'b1;
    observeWindow(80, lowCnt, firstLow, doneCnt, firstDone, busyAtDone);
    checkOutput("f_no_done", doneCnt, 0);
    checkOutput("f_no_tg_low", lowCnt, 0);
    checkActive("f_act", SET_1080, 12'd320);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
